// File: rtl/twiddle_angle_gen.sv
// Purpose : streams the FFT twiddle angles -k*2*pi/2^STAGE (or +k*... for the
//           inverse transform) for k = 0..2^(STAGE-1)-1, one index per transfer.
// Latency : first angle valid the cycle after an accepted start; 1 sample/cycle.
// Backpr. : o_valid/i_ready handshake; the current angle is held until accepted.
// Ports   : i_clk/i_rst_n clock and async active-low reset; i_start/i_inverse
//           request a sequence and pick its sign; i_clear aborts; i_ready accepts
//           o_angle/o_index/o_last under o_valid; o_busy while running; o_done
//           pulses once after the final transfer.
module twiddle_angle_gen #(
    parameter int STAGE   = 5,
    parameter int DATA_W  = 32,
    parameter int FRAC_W  = 16,
    parameter int GUARD_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_inverse,
    input  logic              i_clear,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_angle,
    output logic [STAGE-1:0]  o_index,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam int ACC_W = DATA_W + GUARD_W;
    localparam int CNT   = 1 << (STAGE - 1);
    localparam logic [STAGE-1:0] LAST_K = STAGE'(CNT - 1);

    // Angle step 2*pi/2^STAGE expressed with FRAC_W+GUARD_W fractional bits,
    // rounded to nearest at elaboration. The guard bits keep the accumulated
    // step error well below half an output LSB over the whole sequence.
    localparam real   TWO_PI = 6.283185307179586;
    localparam real   STEP_R = TWO_PI * (2.0 ** (FRAC_W + GUARD_W - STAGE));
    localparam longint STEP_L = longint'(STEP_R);
    localparam logic [ACC_W-1:0] STEP  = ACC_W'(STEP_L);
    localparam logic [ACC_W-1:0] ROUND = ACC_W'(1) << (GUARD_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [STAGE-1:0]   k_q, k_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               inv_q, inv_d;
    logic               done_q, done_d;

    logic [ACC_W-1:0]   acc_rnd;
    logic [DATA_W-1:0]  mag;
    logic               xfer;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            inv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
        end
    end

    assign xfer = (state_q == RUN) && i_ready;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        inv_d   = inv_q;
        done_d  = 1'b0;

        if (i_clear) begin
            state_d = IDLE;
            k_d     = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Also reached in the o_done cycle, so back-to-back
                    // sequences lose no cycle.
                    if (i_start) begin
                        state_d = RUN;
                        k_d     = '0;
                        acc_d   = '0;
                        inv_d   = i_inverse;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (k_q == LAST_K) begin
                            state_d = IDLE;
                            k_d     = '0;
                            acc_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            k_d   = k_q + STAGE'(1);
                            acc_d = acc_q + STEP;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Round half up by adding half an output LSB before dropping guard bits.
    assign acc_rnd = acc_q + ROUND;
    assign mag     = DATA_W'(acc_rnd >> GUARD_W);

    assign o_valid = (state_q == RUN);
    assign o_busy  = (state_q == RUN);
    assign o_angle = inv_q ? mag : -mag;
    assign o_index = k_q;
    assign o_last  = (state_q == RUN) && (k_q == LAST_K);
    assign o_done  = done_q;

endmodule

// File: tb/tb_twiddle_angle_gen.sv
module tb_twiddle_angle_gen;

    localparam real PI2 = 6.283185307179586;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start, inverse, clear, ready;
    logic        valid, last, busy, done;
    logic [31:0] angle;
    logic [4:0]  index;

    logic        sw_start, sw_inv, sw_clear, sw_ready;
    logic [12:1]        sw_valid, sw_last, sw_busy, sw_done;
    logic [12:1][31:0]  sw_angle;
    logic [12:1][11:0]  sw_idx;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference state.
    bit m_active, m_inv, m_done;
    int m_k;

    logic [31:0] tx_angle [0:63];
    int          tx_idx   [0:63];
    bit          tx_last  [0:63];
    logic [31:0] ref_fwd  [0:15];

    always #5 clk = ~clk;

    twiddle_angle_gen dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_inverse(inverse),
        .i_clear  (clear),
        .i_ready  (ready),
        .o_valid  (valid),
        .o_angle  (angle),
        .o_index  (index),
        .o_last   (last),
        .o_busy   (busy),
        .o_done   (done)
    );

    for (genvar g = 1; g <= 12; g++) begin : g_sw
        logic [g-1:0] idx;
        twiddle_angle_gen #(.STAGE(g), .GUARD_W(32)) u_sw (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_start  (sw_start),
            .i_inverse(sw_inv),
            .i_clear  (sw_clear),
            .i_ready  (sw_ready),
            .o_valid  (sw_valid[g]),
            .o_angle  (sw_angle[g]),
            .o_index  (idx),
            .o_last   (sw_last[g]),
            .o_busy   (sw_busy[g]),
            .o_done   (sw_done[g])
        );
        assign sw_idx[g] = 12'(idx);
    end

    // Real-number angle: round-half-up(k * 2*pi / 2^stage * 2^16), signed by direction.
    function automatic logic [31:0] ref_angle(input int stage, input int k, input bit inv);
        real x;
        longint m;
        logic [31:0] r;
        x = real'(k) * PI2 * (2.0 ** (16 - stage));
        m = longint'($floor(x + 0.5));
        r = 32'(m);
        return inv ? r : -r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_inv <= 1'b0; m_done <= 1'b0; m_k <= 0;
        end else if (clear) begin
            m_active <= 1'b0; m_done <= 1'b0; m_k <= 0;
        end else if (m_active) begin
            m_done <= 1'b0;
            if (ready) begin
                if (m_k == 15) begin
                    m_active <= 1'b0; m_done <= 1'b1; m_k <= 0;
                end else begin
                    m_k <= m_k + 1;
                end
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_active <= 1'b1; m_k <= 0; m_inv <= inverse;
            end
        end
    end

    task automatic chk(input string name, input int tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, tag, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare the main DUT with the model.
    task automatic tick();
        @(negedge clk);
        chk("valid", m_k, 64'(valid), 64'(m_active));
        chk("busy",  m_k, 64'(busy),  64'(m_active));
        chk("done",  m_k, 64'(done),  64'(m_done));
        if (m_active) begin
            chk("index", m_k, 64'(index), 64'(m_k));
            chk("angle", m_k, 64'(angle), 64'(ref_angle(5, m_k, m_inv)));
            chk("last",  m_k, 64'(last),  64'(m_k == 15));
        end
    endtask

    task automatic run_seq(input bit inv, input bit rand_rdy, input int dup_start_at,
                           output int ntx, output bit seen_done);
        ntx = 0;
        seen_done = 1'b0;
        start = 1'b1; inverse = inv; ready = 1'b1;
        tick();
        start = 1'b0;
        inverse = ~inv;
        for (int c = 0; c < 400; c++) begin
            ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (c == dup_start_at);
            if (valid && ready && ntx < 64) begin
                tx_angle[ntx] = angle;
                tx_idx[ntx]   = int'(index);
                tx_last[ntx]  = last;
                ntx++;
            end
            tick();
            if (done) begin
                seen_done = 1'b1;
                break;
            end
        end
        start = 1'b0; ready = 1'b1; inverse = 1'b0;
    endtask

    task automatic sweep(input bit inv);
        sw_inv = inv;
        sw_start = 1'b1;
        tick();
        sw_start = 1'b0;
        for (int t = 0; t <= 2048; t++) begin
            for (int s = 1; s <= 12; s++) begin
                int cnt;
                cnt = 1 << (s - 1);
                if (t < cnt) begin
                    chk("sw_valid", s, 64'(sw_valid[s]), 64'(1));
                    chk("sw_index", s, 64'(sw_idx[s]), 64'(t));
                    chk("sw_angle", s * 4096 + t, 64'(sw_angle[s]), 64'(ref_angle(s, t, inv)));
                    chk("sw_last",  s, 64'(sw_last[s]), 64'(t == cnt - 1));
                end else if (t == cnt) begin
                    chk("sw_done", s, 64'({sw_done[s], sw_valid[s], sw_busy[s]}), 64'(3'b100));
                end
            end
            tick();
        end
    endtask

    initial begin
        int  ntx;
        bit  seen;
        start = 1'b0; inverse = 1'b0; clear = 1'b0; ready = 1'b1;
        sw_start = 1'b0; sw_inv = 1'b0; sw_clear = 1'b0; sw_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_valid", 0, 64'(valid), 64'(0));
        chk("rst_angle", 0, 64'(angle), 64'(0));
        chk("rst_index", 0, 64'(index), 64'(0));
        chk("rst_last",  0, 64'(last),  64'(0));
        chk("rst_busy",  0, 64'(busy),  64'(0));
        chk("rst_done",  0, 64'(done),  64'(0));
        rst_n = 1'b1;
        tick();

        // Forward sequence, always ready.
        run_seq(1'b0, 1'b0, -1, ntx, seen);
        chk("fwd_len", 0, 64'(ntx), 64'(16));
        chk("fwd_done", 0, 64'(seen), 64'(1));
        for (int i = 0; i < 16; i++) ref_fwd[i] = tx_angle[i];
        chk("fwd_k0",  0,  64'(tx_angle[0]),  64'(32'h0000_0000));
        chk("fwd_k1",  1,  64'(tx_angle[1]),  64'(32'hFFFF_CDBC));
        chk("fwd_k8",  8,  64'(tx_angle[8]),  64'(32'hFFFE_6DE0));
        chk("fwd_k14", 14, 64'(tx_angle[14]), 64'(32'hFFFD_4049));
        chk("fwd_k15", 15, 64'(tx_angle[15]), 64'(32'hFFFD_0E05));
        chk("fwd_last15", 15, 64'(tx_last[15]), 64'(1));
        chk("fwd_last14", 14, 64'(tx_last[14]), 64'(0));
        tick();

        // Inverse sequence.
        run_seq(1'b1, 1'b0, -1, ntx, seen);
        chk("inv_len", 0, 64'(ntx), 64'(16));
        chk("inv_k1",  1,  64'(tx_angle[1]),  64'(32'h0000_3244));
        chk("inv_k4",  4,  64'(tx_angle[4]),  64'(32'h0000_C910));
        chk("inv_k15", 15, 64'(tx_angle[15]), 64'(32'h0002_F1FB));
        tick();

        // Random backpressure: accepted stream must equal the unstalled one.
        run_seq(1'b0, 1'b1, -1, ntx, seen);
        chk("bp_len", 0, 64'(ntx), 64'(16));
        chk("bp_done", 0, 64'(seen), 64'(1));
        for (int i = 0; i < 16; i++) begin
            chk("bp_idx",   i, 64'(tx_idx[i]),   64'(i));
            chk("bp_angle", i, 64'(tx_angle[i]), 64'(ref_fwd[i]));
        end
        tick();

        // Start during RUN ignored; start in the done cycle accepted.
        run_seq(1'b0, 1'b0, 5, ntx, seen);
        chk("dup_len", 0, 64'(ntx), 64'(16));
        start = 1'b1; inverse = 1'b1;
        tick();
        start = 1'b0; inverse = 1'b0;
        chk("b2b_valid", 0, 64'({valid, index}), 64'({1'b1, 5'd0}));
        for (int c = 0; c < 40 && !done; c++) tick();
        chk("b2b_done", 0, 64'(done), 64'(1));
        tick();

        // Clear at k=6.
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40 && !(valid && index == 5'd6); c++) tick();
        chk("reach_k6", 0, 64'({valid, index}), 64'({1'b1, 5'd6}));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_state", 0, 64'({valid, busy, done}), 64'(0));
        tick();
        chk("clr_nodone", 0, 64'(done), 64'(0));
        run_seq(1'b0, 1'b0, -1, ntx, seen);
        chk("clr_restart_len", 0, 64'(ntx), 64'(16));
        chk("clr_restart_k0", 0, 64'({tx_idx[0], tx_angle[0]}), 64'(0));
        tick();

        // Asynchronous reset at k=3.
        start = 1'b1; ready = 1'b1; inverse = 1'b1;
        tick();
        start = 1'b0; inverse = 1'b0;
        for (int c = 0; c < 40 && !(valid && index == 5'd3); c++) tick();
        chk("reach_k3", 0, 64'({valid, index}), 64'({1'b1, 5'd3}));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 0, 64'(valid), 64'(0));
        chk("arst_angle", 0, 64'(angle), 64'(0));
        chk("arst_index", 0, 64'(index), 64'(0));
        chk("arst_last",  0, 64'(last),  64'(0));
        chk("arst_busy",  0, 64'(busy),  64'(0));
        chk("arst_done",  0, 64'(done),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        // Stage sweep against the real-number model.
        sweep(1'b0);
        sweep(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/twiddle_angle_gen.md
TWIDDLE_ANGLE_GEN -- requirements
Module: twiddle_angle_gen

Interface
REQ-001 Parameter STAGE, default 5: FFT stage; sequence length CNT = 2^(STAGE-1); legal range 1..12.
REQ-002 Parameter DATA_W, default 32: width of o_angle, two's complement.
REQ-003 Parameter FRAC_W, default 16: fractional bits of o_angle in radians (Q(DATA_W-FRAC_W).FRAC_W).
REQ-004 Parameter GUARD_W, default 16: extra fractional bits held in the internal phase accumulator.
REQ-005 i_clk  input  1  single clock, all state on rising edge.
REQ-006 i_rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_start  input  1  request one full angle sequence; honoured only in IDLE.
REQ-008 i_inverse  input  1  sampled with accepted i_start; 1 = positive angles (IFFT), 0 = negative (FFT).
REQ-009 i_clear  input  1  synchronous abort, returns to IDLE.
REQ-010 i_ready  input  1  downstream accepts o_angle this cycle.
REQ-011 o_valid  output  1  o_angle/o_index/o_last valid.
REQ-012 o_angle  output  DATA_W  twiddle angle for index o_index.
REQ-013 o_index  output  STAGE  current index k (width 1 when STAGE=1).
REQ-014 o_last  output  1  high with valid when k = CNT-1.
REQ-015 o_busy  output  1  high in RUN.
REQ-016 o_done  output  1  one-cycle pulse after last transfer.

Function
REQ-017 Two-state FSM: IDLE, RUN.
REQ-018 IDLE -> RUN on i_start=1 and i_clear=0; next cycle o_valid=1, k=0, o_angle=0 (latency 1 cycle).
REQ-019 Transfer occurs on o_valid & i_ready; on transfer with k<CNT-1, next cycle k=k+1 and new angle (throughput 1 sample/cycle).
REQ-020 o_valid=1 & i_ready=0: o_angle, o_index, o_last held stable, o_valid stays 1.
REQ-021 Transfer with k=CNT-1: next cycle state IDLE, o_valid=0, o_done=1 for exactly one cycle.
REQ-022 i_start in RUN ignored; i_start in the cycle o_done is high is accepted (IDLE already).
REQ-023 Magnitude |angle(k)| = round-half-up(k * 2*pi / 2^STAGE * 2^FRAC_W), produced without a lookup table.
REQ-024 Implementation: unsigned accumulator of width DATA_W+GUARD_W; STEP = round(2*pi * 2^(FRAC_W+GUARD_W) / 2^STAGE) computed at elaboration; acc cleared at start, acc += STEP per transfer.
REQ-025 Magnitude = (acc + 2^(GUARD_W-1)) >> GUARD_W; o_angle = -magnitude when inverse latched 0, +magnitude when 1; truncated to DATA_W.
REQ-026 Result SHALL match REQ-023 bit-exactly for every k at STAGE<=12, GUARD_W>=16.
REQ-027 i_clear has priority over all: next cycle IDLE, o_valid=0, o_busy=0, o_done=0, acc=0, k=0; no o_done pulse.
REQ-028 STAGE=1: single sample angle 0 with o_last=1.
REQ-029 i_inverse changes during RUN have no effect.

Reset
REQ-030 i_rst_n=0 immediately (asynchronous) forces IDLE, o_valid=0, o_angle=0, o_index=0, o_last=0, o_busy=0, o_done=0, acc=0, inverse latch=0.
REQ-031 Reset deasserted synchronously to i_clk externally; first active edge after release treated normally.
REQ-032 Reset mid-RUN aborts sequence; no o_done.

Verification
REQ-033 STAGE=5, FRAC_W=16, i_ready=1, start inverse=0 -> 16 consecutive valid cycles: k=0 0x00000000, k=1 0xFFFFCDBC, k=8 0xFFFE6DE0, k=14 0xFFFD4049, k=15 0xFFFD0E05 with o_last=1; o_done next cycle.
REQ-034 Same with inverse=1 -> k=1 0x00003244, k=4 0x0000C910, k=15 0x0002F1FB.
REQ-035 Random i_ready backpressure -> each angle held until accepted; sequence identical to REQ-033, no skips/duplicates.
REQ-036 i_clear asserted at k=6 -> next cycle o_valid=0, no o_done; new start restarts at k=0 angle 0.
REQ-037 i_rst_n low at k=3 -> outputs zero asynchronously before next edge; i_start during RUN -> ignored, sequence length still 16.
REQ-038 Sweep STAGE 1..12 against real-number model -> all CNT angles bit-exact per REQ-023.
